// File: rtl/ls446_bus_sequencer.sv
// rtl/ls446_bus_sequencer.sv - two-requester sequencer/arbiter for one sn74ls446 bus transceiver
// Guarantees direction setup, dead-time turnaround, round-robin ties and hold preemption.
module ls446_bus_sequencer #(
    parameter int unsigned SETUP_CYC = 1,
    parameter int unsigned TURN_CYC  = 2,
    parameter int unsigned MAX_HOLD  = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_ab,
    input  logic [3:0] mask_ab,
    input  logic       req_ba,
    input  logic [3:0] mask_ba,
    output logic       gnt_ab,
    output logic       gnt_ba,
    output logic       gab,
    output logic       gba,
    output logic [3:0] dir,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_DRIVE,
        S_TURN
    } state_t;

    localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYC - 1);
    localparam logic [7:0] TURN_LAST  = 8'(TURN_CYC - 1);
    localparam logic [7:0] HOLD_MAX   = 8'(MAX_HOLD);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       owner_ba_q, owner_ba_d;
    logic       last_ba_q, last_ba_d;
    logic [3:0] dir_q, dir_d;
    logic       gab_q, gab_d;
    logic       gba_q, gba_d;
    logic       gnt_ab_q, gnt_ab_d;
    logic       gnt_ba_q, gnt_ba_d;
    logic       busy_q, busy_d;

    logic       owner_req;
    logic       other_req;

    always_comb begin
        owner_req = owner_ba_q ? req_ba : req_ab;
        other_req = owner_ba_q ? req_ab : req_ba;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        owner_ba_d = owner_ba_q;
        last_ba_d  = last_ba_q;
        dir_d      = dir_q;
        gab_d      = 1'b1;
        gba_d      = 1'b1;
        gnt_ab_d   = 1'b0;
        gnt_ba_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A tie goes to whichever side did not own the bus last.
                if (req_ab && (!req_ba || last_ba_q)) begin
                    owner_ba_d = 1'b0;
                    dir_d      = mask_ab;
                    cnt_d      = 8'd0;
                    state_d    = S_SETUP;
                end else if (req_ba) begin
                    owner_ba_d = 1'b1;
                    dir_d      = ~mask_ba;
                    cnt_d      = 8'd0;
                    state_d    = S_SETUP;
                end
            end

            S_SETUP: begin
                if (!owner_req) begin
                    cnt_d   = 8'd0;
                    state_d = S_IDLE;
                end else if (cnt_q == SETUP_LAST) begin
                    cnt_d    = 8'd0;
                    state_d  = S_DRIVE;
                    gab_d    = owner_ba_q;
                    gba_d    = !owner_ba_q;
                    gnt_ab_d = !owner_ba_q;
                    gnt_ba_d = owner_ba_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            S_DRIVE: begin
                if (!owner_req || (cnt_q == HOLD_MAX && other_req)) begin
                    cnt_d     = 8'd0;
                    last_ba_d = owner_ba_q;
                    state_d   = S_TURN;
                end else begin
                    gab_d    = owner_ba_q;
                    gba_d    = !owner_ba_q;
                    gnt_ab_d = !owner_ba_q;
                    gnt_ba_d = owner_ba_q;
                    // Saturate so an uncontested owner can hold indefinitely.
                    cnt_d    = (cnt_q == HOLD_MAX) ? cnt_q : cnt_q + 8'd1;
                end
            end

            S_TURN: begin
                if (cnt_q == TURN_LAST) begin
                    cnt_d   = 8'd0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end

            default: begin
                cnt_d   = 8'd0;
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            owner_ba_q <= 1'b0;
            last_ba_q  <= 1'b1;
            dir_q      <= 4'b0000;
            gab_q      <= 1'b1;
            gba_q      <= 1'b1;
            gnt_ab_q   <= 1'b0;
            gnt_ba_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            owner_ba_q <= owner_ba_d;
            last_ba_q  <= last_ba_d;
            dir_q      <= dir_d;
            gab_q      <= gab_d;
            gba_q      <= gba_d;
            gnt_ab_q   <= gnt_ab_d;
            gnt_ba_q   <= gnt_ba_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt_ab = gnt_ab_q;
    assign gnt_ba = gnt_ba_q;
    assign gab    = gab_q;
    assign gba    = gba_q;
    assign dir    = dir_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_ls446_bus_sequencer.sv
// tb/tb_ls446_bus_sequencer.sv - self-checking bench for ls446_bus_sequencer
// Directed scenarios plus random traffic against a phase-countdown reference model.
module tb_ls446_bus_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_ab = 1'b0;
    logic [3:0] mask_ab = 4'b0000;
    logic       req_ba = 1'b0;
    logic [3:0] mask_ba = 4'b0000;
    logic       gnt_ab, gnt_ba, gab, gba, busy;
    logic [3:0] dir;

    int n_checks = 0;
    int n_fail = 0;

    ls446_bus_sequencer #(.SETUP_CYC(1), .TURN_CYC(2), .MAX_HOLD(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_ab(req_ab), .mask_ab(mask_ab),
        .req_ba(req_ba), .mask_ba(mask_ba),
        .gnt_ab(gnt_ab), .gnt_ba(gnt_ba),
        .gab(gab), .gba(gba), .dir(dir), .busy(busy)
    );

    always #5 clk = ~clk;

    localparam logic [8:0] P_SETUP = 9'd1;
    localparam logic [8:0] P_TURN  = 9'd2;
    localparam logic [8:0] P_HOLD  = 9'd16;

    // own: 0 none, 1 AB, 2 BA; setup/turn count down remaining cycles of each phase.
    typedef struct packed {
        logic [1:0] own;
        logic [8:0] setup;
        logic       drv;
        logic [8:0] held;
        logic [8:0] turn;
        logic       last_ab;
        logic [3:0] dir;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t step(mstate_t s, logic ra, logic rb, logic [3:0] ma, logic [3:0] mb);
        mstate_t n;
        logic oreq, xreq;
        n = s;
        oreq = (s.own == 2'd1) ? ra : rb;
        xreq = (s.own == 2'd1) ? rb : ra;
        if (s.setup != 9'd0) begin
            if (!oreq) begin
                n.setup = 9'd0;
                n.own = 2'd0;
            end else begin
                n.setup = s.setup - 9'd1;
                if (s.setup == 9'd1) begin
                    n.drv = 1'b1;
                    n.held = 9'd0;
                end
            end
        end else if (s.drv) begin
            if (!oreq || (s.held >= P_HOLD && xreq)) begin
                n.drv = 1'b0;
                n.last_ab = (s.own == 2'd1);
                n.own = 2'd0;
                n.turn = P_TURN;
            end else if (s.held < P_HOLD) begin
                n.held = s.held + 9'd1;
            end
        end else if (s.turn != 9'd0) begin
            n.turn = s.turn - 9'd1;
        end else if (ra && (!rb || !s.last_ab)) begin
            n.own = 2'd1;
            n.dir = ma;
            n.setup = P_SETUP;
        end else if (rb) begin
            n.own = 2'd2;
            n.dir = ~mb;
            n.setup = P_SETUP;
        end
        return n;
    endfunction

    function automatic logic [8:0] mexp(mstate_t s);
        logic da, db;
        da = s.drv && (s.own == 2'd1);
        db = s.drv && (s.own == 2'd2);
        return {~da, ~db, da, db, (s.own != 2'd0) || (s.turn != 9'd0), s.dir};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '{own: 2'd0, setup: 9'd0, drv: 1'b0, held: 9'd0,
                           turn: 9'd0, last_ab: 1'b0, dir: 4'b0000};
        else        m <= step(m, req_ab, req_ba, mask_ab, mask_ba);
    end

    logic [8:0] obs;
    assign obs = {gab, gba, gnt_ab, gnt_ba, busy, dir};

    function automatic logic [8:0] v(logic a, logic b, logic c, logic d, logic e, logic [3:0] dr);
        return {a, b, c, d, e, dr};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_ab = 1'b1; req_ba = 1'b0; mask_ab = 4'b0110; mask_ba = 4'b0000;
        tick(); tick();
        n_checks++;
        if (obs !== v(1, 1, 0, 0, 0, 4'b0000)) begin n_fail++; $display("FAIL reset_hold got %b want %b", obs, v(1, 1, 0, 0, 0, 4'b0000)); end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (obs !== v(1, 1, 0, 0, 1, 4'b0110)) begin n_fail++; $display("FAIL reset_setup got %b want %b", obs, v(1, 1, 0, 0, 1, 4'b0110)); end
        tick();
        n_checks++;
        if (obs !== v(0, 1, 1, 0, 1, 4'b0110)) begin n_fail++; $display("FAIL first_grant got %b want %b", obs, v(0, 1, 1, 0, 1, 4'b0110)); end
        req_ab = 1'b0;
        tick(); tick();
        n_checks++;
        if (obs !== v(1, 1, 0, 0, 1, 4'b0110)) begin n_fail++; $display("FAIL ab_turn got %b want %b", obs, v(1, 1, 0, 0, 1, 4'b0110)); end
        tick();
        n_checks++;
        if (obs !== v(1, 1, 0, 0, 0, 4'b0110)) begin n_fail++; $display("FAIL ab_idle got %b want %b", obs, v(1, 1, 0, 0, 0, 4'b0110)); end
    endtask

    task automatic test_single_ba();
        req_ba = 1'b1; mask_ba = 4'b1010;
        tick();
        n_checks++;
        if (obs !== v(1, 1, 0, 0, 1, 4'b0101)) begin n_fail++; $display("FAIL ba_setup got %b want %b", obs, v(1, 1, 0, 0, 1, 4'b0101)); end
        tick();
        n_checks++;
        if (obs !== v(1, 0, 0, 1, 1, 4'b0101)) begin n_fail++; $display("FAIL ba_grant got %b want %b", obs, v(1, 0, 0, 1, 1, 4'b0101)); end
        req_ba = 1'b0;
        tick();
        n_checks++;
        if (obs !== v(1, 1, 0, 0, 1, 4'b0101)) begin n_fail++; $display("FAIL ba_release got %b want %b", obs, v(1, 1, 0, 0, 1, 4'b0101)); end
        tick(); tick();
        n_checks++;
        if (obs !== v(1, 1, 0, 0, 0, 4'b0101)) begin n_fail++; $display("FAIL ba_idle got %b want %b", obs, v(1, 1, 0, 0, 0, 4'b0101)); end
    endtask

    task automatic test_tie();
        rst_n = 1'b0; req_ab = 1'b1; req_ba = 1'b1; mask_ab = 4'b1001; mask_ba = 4'b0100;
        tick();
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (obs !== v(1, 1, 0, 0, 1, 4'b1001)) begin n_fail++; $display("FAIL tie_ab_setup got %b want %b", obs, v(1, 1, 0, 0, 1, 4'b1001)); end
        tick();
        n_checks++;
        if (obs !== v(0, 1, 1, 0, 1, 4'b1001)) begin n_fail++; $display("FAIL tie_ab_grant got %b want %b", obs, v(0, 1, 1, 0, 1, 4'b1001)); end
        tick(); tick();
        req_ab = 1'b0;
        tick();
        n_checks++;
        if (obs !== v(1, 1, 0, 0, 1, 4'b1001)) begin n_fail++; $display("FAIL tie_ab_release got %b want %b", obs, v(1, 1, 0, 0, 1, 4'b1001)); end
        tick(); tick(); tick();
        n_checks++;
        if (obs !== v(1, 1, 0, 0, 1, 4'b1011)) begin n_fail++; $display("FAIL tie_gap_early got %b want %b", obs, v(1, 1, 0, 0, 1, 4'b1011)); end
        tick();
        n_checks++;
        if (obs !== v(1, 0, 0, 1, 1, 4'b1011)) begin n_fail++; $display("FAIL tie_gap_grant got %b want %b", obs, v(1, 0, 0, 1, 1, 4'b1011)); end
        req_ba = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (obs !== v(1, 1, 0, 0, 0, 4'b1011)) begin n_fail++; $display("FAIL tie_idle got %b want %b", obs, v(1, 1, 0, 0, 0, 4'b1011)); end
    endtask

    task automatic test_preempt();
        bit ok;
        req_ab = 1'b1; mask_ab = 4'b1100; req_ba = 1'b0;
        tick(); tick();
        req_ba = 1'b1; mask_ba = 4'b0101;
        ok = 1'b1;
        repeat (16) begin
            tick();
            if (gnt_ab !== 1'b1 || gab !== 1'b0) ok = 1'b0;
        end
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL preempt_hold16 got early release want 16 held cycles"); end
        tick();
        n_checks++;
        if (obs !== v(1, 1, 0, 0, 1, 4'b1100)) begin n_fail++; $display("FAIL preempt_release got %b want %b", obs, v(1, 1, 0, 0, 1, 4'b1100)); end
        tick(); tick(); tick();
        n_checks++;
        if (obs !== v(1, 1, 0, 0, 1, 4'b1010)) begin n_fail++; $display("FAIL preempt_ba_setup got %b want %b", obs, v(1, 1, 0, 0, 1, 4'b1010)); end
        tick();
        n_checks++;
        if (obs !== v(1, 0, 0, 1, 1, 4'b1010)) begin n_fail++; $display("FAIL preempt_ba_grant got %b want %b", obs, v(1, 0, 0, 1, 1, 4'b1010)); end
        req_ab = 1'b0; req_ba = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (obs !== v(1, 1, 0, 0, 0, 4'b1010)) begin n_fail++; $display("FAIL preempt_idle got %b want %b", obs, v(1, 1, 0, 0, 0, 4'b1010)); end
    endtask

    task automatic test_long_hold();
        int held;
        req_ab = 1'b1; mask_ab = 4'b0111;
        tick(); tick();
        held = 0;
        repeat (40) begin
            tick();
            if (gnt_ab === 1'b1 && gab === 1'b0) held++;
        end
        n_checks++;
        if (held !== 40) begin n_fail++; $display("FAIL long_hold got %0d want %0d", held, 40); end
        req_ab = 1'b0;
        tick(); tick(); tick();
        n_checks++;
        if (obs !== v(1, 1, 0, 0, 0, 4'b0111)) begin n_fail++; $display("FAIL long_hold_idle got %b want %b", obs, v(1, 1, 0, 0, 0, 4'b0111)); end
    endtask

    task automatic test_setup_drop();
        rst_n = 1'b0; req_ab = 1'b0; req_ba = 1'b0;
        tick();
        rst_n = 1'b1; req_ab = 1'b1; mask_ab = 4'b0011; mask_ba = 4'b0011;
        tick();
        n_checks++;
        if (obs !== v(1, 1, 0, 0, 1, 4'b0011)) begin n_fail++; $display("FAIL drop_setup got %b want %b", obs, v(1, 1, 0, 0, 1, 4'b0011)); end
        req_ab = 1'b0;
        tick();
        n_checks++;
        if (obs !== v(1, 1, 0, 0, 0, 4'b0011)) begin n_fail++; $display("FAIL drop_idle got %b want %b", obs, v(1, 1, 0, 0, 0, 4'b0011)); end
        req_ab = 1'b1; req_ba = 1'b1;
        tick(); tick();
        n_checks++;
        if (obs !== v(0, 1, 1, 0, 1, 4'b0011)) begin n_fail++; $display("FAIL drop_tiebreak got %b want %b", obs, v(0, 1, 1, 0, 1, 4'b0011)); end
        req_ab = 1'b0; req_ba = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_async_reset();
        req_ab = 1'b1; mask_ab = 4'b1111;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs !== v(1, 1, 0, 0, 0, 4'b0000)) begin n_fail++; $display("FAIL async_reset got %b want %b", obs, v(1, 1, 0, 0, 0, 4'b0000)); end
        @(negedge clk);
        rst_n = 1'b1; req_ab = 1'b0;
    endtask

    task automatic test_random();
        int bad_model, bad_inv;
        bad_model = 0; bad_inv = 0;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 5) == 0) req_ab = ~req_ab;
            if ($urandom_range(0, 5) == 0) req_ba = ~req_ba;
            mask_ab = 4'($urandom);
            mask_ba = 4'($urandom);
            tick();
            n_checks++;
            if (obs !== mexp(m)) begin
                n_fail++;
                if (bad_model < 5) $display("FAIL random_model cycle %0d got %b want %b", i, obs, mexp(m));
                bad_model++;
            end
            n_checks++;
            if (gab === 1'b0 && gba === 1'b0) begin
                n_fail++;
                if (bad_inv < 5) $display("FAIL random_both_enabled cycle %0d got gab=%b gba=%b want not both 0", i, gab, gba);
                bad_inv++;
            end
        end
        req_ab = 1'b0; req_ba = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_ba();
        test_tie();
        test_preempt();
        test_long_hold();
        test_setup_drop();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
